// File: rtl/miner_pkg.sv
// Shared constants, golden-nonce payload type and pipeline-offset helper for the mining control unit.
package miner_pkg;

    localparam int unsigned CORE_W  = 3;
    localparam int unsigned NONCE_W = 32;

    // First-stage block padding placed above the nonce and header tail
    localparam logic [383:0] PAD384 = 384'h00000280_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

    // Second-stage hasher constants (initial state and block padding above hash1)
    localparam logic [255:0] IV256  = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] PAD256 = 256'h00000100_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

    typedef struct packed {
        logic [CORE_W-1:0]  core;
        logic [NONCE_W-1:0] nonce;
    } golden_t;

    // Batches between a nonce entering the hashers and its hash2 being observable
    function automatic int unsigned golden_offset(input int unsigned loop_log2);
        if (loop_log2 == 32'd0) begin
            return 32'd131;
        end else if (loop_log2 == 32'd1) begin
            return 32'd66;
        end else begin
            return (32'd1 << (32'd7 - loop_log2)) + 32'd1;
        end
    endfunction

endpackage

// File: rtl/golden_fifo.sv
// Golden-nonce FIFO; a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module golden_fifo
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  golden_t push_data,
    input  logic    pop,
    output golden_t head,
    output logic    empty,
    output logic    full,
    output logic    drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    golden_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        drop_c     = push && !push_ok;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/nonce_dispatcher.sv
// Mining control: sequences the shared hasher round counter, hands out interleaved nonces,
// detects golden hash2 results and queues offset-corrected nonces for the consumer.
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int unsigned LOOP_LOG2  = 5,
    parameter int unsigned NCORES     = 2,
    parameter int unsigned DIFF_BITS  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    hash_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    work_valid,
    input  logic [511:0]            work_data,
    output logic [5:0]              cnt,
    output logic                    feedback,
    output logic [255:0]            core_state,
    output logic [NCORES*512-1:0]   core_data,
    input  logic [NCORES*256-1:0]   core_hash,
    output logic [NONCE_W-1:0]      base_nonce,
    output logic                    gn_valid,
    input  logic                    gn_ready,
    output logic [NONCE_W-1:0]      gn_data,
    output logic [CORE_W-1:0]       gn_core,
    output logic                    overflow
);

    localparam int unsigned  LOOP       = 1 << LOOP_LOG2;
    localparam int unsigned  OFS        = golden_offset(LOOP_LOG2);
    localparam int unsigned  WARM_W     = 8;
    localparam logic [5:0]   CNT_MASK   = 6'(LOOP - 1);
    localparam logic [31:0]  NONCE_STEP = 32'(NCORES);
    localparam logic [31:0]  NONCE_OFS  = 32'(OFS * NCORES);

    logic [255:0]                   midstate;
    logic [95:0]                    tail;
    logic                           feedback_d1;
    logic [WARM_W-1:0]              warm_cnt;
    logic [NCORES-1:0]              g;
    logic [NCORES-1:0][31:0]        g_nonce;
    logic [NCORES-1:0]              pending;
    logic [NCORES-1:0][31:0]        pend_nonce;

    logic [5:0]                     cnt_next;
    logic                           feedback_next;
    logic [31:0]                    base_next;
    logic [NCORES*512-1:0]          core_data_next;
    logic                           warm;
    logic [NCORES-1:0]              g_next;
    logic [NCORES-1:0][31:0]        g_nonce_next;
    logic [NCORES-1:0]              pend_next;
    logic [NCORES-1:0][31:0]        pend_nonce_next;
    logic                           pend_drop;
    logic                           drain_any;
    golden_t                        drain_entry;
    golden_t                        head;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           fifo_drop_c;
    logic                           pop;
    logic                           unused_bits;

    // Round sequencing, per-core blocks and golden detection
    always_comb begin
        cnt_next       = (cnt + 6'd1) & CNT_MASK;
        feedback_next  = (LOOP > 1) && (cnt_next != '0);
        base_next      = feedback_next ? base_nonce : base_nonce + NONCE_STEP;
        warm           = (warm_cnt >= WARM_W'(OFS));
        core_data_next = '0;
        g_next         = '0;
        g_nonce_next   = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            core_data_next[k*512 +: 512] = {PAD384, base_next + 32'(k), tail};
            g_next[k]       = enable && !feedback_d1 && warm &&
                              (core_hash[k*256 + 255 -: DIFF_BITS] == '0);
            g_nonce_next[k] = base_nonce + 32'(k) - NONCE_OFS;
        end
    end

    // Lowest pending core drains to the FIFO; a repeat hit on a still-pending core is lost
    always_comb begin
        drain_any       = 1'b0;
        drain_entry     = '0;
        pend_next       = pending;
        pend_nonce_next = pend_nonce;
        pend_drop       = 1'b0;
        for (int k = int'(NCORES) - 1; k >= 0; k--) begin
            if (pending[k]) begin
                drain_any         = 1'b1;
                drain_entry.core  = CORE_W'(k);
                drain_entry.nonce = pend_nonce[k];
            end
        end
        for (int unsigned k = 0; k < NCORES; k++) begin
            if (drain_any && (drain_entry.core == CORE_W'(k))) begin
                pend_next[k] = 1'b0;
            end
        end
        for (int unsigned k = 0; k < NCORES; k++) begin
            if (g[k]) begin
                if (pend_next[k]) begin
                    pend_drop = 1'b1;
                end else begin
                    pend_next[k]       = 1'b1;
                    pend_nonce_next[k] = g_nonce[k];
                end
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            midstate    <= '0;
            tail        <= '0;
            cnt         <= '0;
            feedback    <= 1'b0;
            feedback_d1 <= 1'b1;
            base_nonce  <= '0;
            core_state  <= '0;
            core_data   <= '0;
            warm_cnt    <= '0;
            g           <= '0;
            g_nonce     <= '0;
            pending     <= '0;
            pend_nonce  <= '0;
            overflow    <= 1'b0;
        end else begin
            pend_nonce <= pend_nonce_next;
            g_nonce    <= g_nonce_next;
            if (work_valid) begin
                midstate    <= work_data[511:256];
                tail        <= work_data[95:0];
                cnt         <= '0;
                feedback    <= 1'b0;
                feedback_d1 <= 1'b1;
                base_nonce  <= '0;
                warm_cnt    <= '0;
                g           <= '0;
                pending     <= '0;
            end else begin
                feedback_d1 <= feedback;
                g           <= g_next;
                pending     <= pend_next;
                if (enable) begin
                    cnt        <= cnt_next;
                    feedback   <= feedback_next;
                    base_nonce <= base_next;
                    core_state <= midstate;
                    core_data  <= core_data_next;
                    if (!feedback_next && (warm_cnt != WARM_W'(OFS))) begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end else begin
                    warm_cnt <= '0;
                end
            end
            if (pend_drop || fifo_drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pop = !fifo_empty && gn_ready;

    golden_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (hash_clk),
        .rst_n     (rst_n),
        .push      (drain_any),
        .push_data (drain_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop_c    (fifo_drop_c)
    );

    assign gn_valid    = !fifo_empty;
    assign gn_data     = head.nonce;
    assign gn_core     = head.core;
    assign unused_bits = ^{work_data[255:96], core_hash, fifo_full};

endmodule
